airi5c_periph_bridge: RTL and testbench
=======================================

Name: airi5c_periph_bridge

Overview:
- HASTI (AHB-lite) slave-side bridge for one internal peripheral. It sits directly upstream of the peripheral read mux and drives one of that mux's slave ports (hready/hresp/hrdata).
- Converts pipelined AHB address/data phases into a simple registered req/ack register interface toward the peripheral core (UART, SPI, GPIO, timer).
- Generates a legal two-cycle ERROR response for illegal accesses and for peripheral errors.

Parameters:
- ADDR_WIDTH, 8, number of low haddr bits forwarded to the peripheral as p_addr.
- TIMEOUT_CYCLES, 255, ACCESS cycles before a forced error; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- hsel  in  1  slave select from the address decoder.
- haddr  in  32  address-phase address.
- hwrite  in  1  address-phase write flag.
- hsize  in  3  address-phase transfer size.
- htrans  in  2  address-phase transfer type.
- hwdata  in  32  data-phase write data.
- hready_in  in  1  bus-level hready (the mux output m_hready).
- hready_out  out  1  this slave's hready, to the mux s_hready.
- hresp  out  `HASTI_RESP_WIDTH  this slave's response.
- hrdata  out  32  read data.
- p_req  out  1  peripheral access request.
- p_we  out  1  write enable.
- p_addr  out  ADDR_WIDTH  register address.
- p_be  out  4  byte enables.
- p_wdata  out  32  write data.
- p_ack  in  1  peripheral done, one-cycle pulse.
- p_err  in  1  peripheral error, valid with p_ack.
- p_rdata  in  32  read data, valid with p_ack.

Behaviour:
- Reset:
  - Every output is registered and is reset on rst_i at the clock edge.
  - Reset values: state=IDLE, hready_out=1, hresp=`HASTI_RESP_OKAY, hrdata=0, p_req=0, p_we=0, p_addr=0, p_be=0, p_wdata=0.
  - Reset asserted mid-access drops p_req at that edge; a late p_ack is ignored.
- Capture:
  - A transfer is accepted when hsel & htrans[1] & hready_in are high at a clock edge.
  - The bridge then latches haddr, hwrite and hsize.
  - IDLE/BUSY htrans are never accepted.
- Legality:
  - Illegal means hsize>2, halfword with haddr[0]=1, or word with haddr[1:0]!=0.
  - An illegal transfer goes to ERR1 and the peripheral is never accessed.
- Byte enables:
  - Byte: 4'b0001<<haddr[1:0].
  - Halfword: 4'b0011<<{haddr[1],1'b0}.
  - Word: 4'b1111.
- FSM:
  - IDLE: hready_out=1, hresp OKAY. A legal accept goes to ACCESS; an illegal accept goes to ERR1.
  - ACCESS:
    - Entry edge sets p_req=1, p_we, p_addr=haddr[ADDR_WIDTH-1:0] and p_be; hready_out=0.
    - While in ACCESS, p_wdata is loaded from hwdata on every edge (hwdata is stable during the data phase).
    - p_ack&!p_err goes to RESP, with p_req=0 and hrdata<=p_rdata (hrdata<=0 on writes).
    - p_ack&p_err goes to ERR1, with p_req=0.
  - RESP:
    - hready_out=1, hresp OKAY for exactly one cycle.
    - A new accept in this cycle goes to ACCESS or ERR1 (back-to-back); otherwise go to IDLE.
  - ERR1: hready_out=0, hresp ERROR, then go to ERR2.
  - ERR2:
    - hready_out=1, hresp ERROR.
    - An accept in this cycle is handled as in RESP; otherwise go to IDLE.
- Latency:
  - A read with p_ack in the first ACCESS cycle completes its data phase in 2 cycles: ACCESS, then RESP.
  - Each extra peripheral wait cycle adds 1 cycle.
- p_ack outside ACCESS is ignored. p_req is never high outside ACCESS.
- hrdata holds its value outside RESP.

Optional Feature:
- Macro: AIRI5C_PERIPH_BRIDGE_TIMEOUT_EN.
- With the macro:
  - A counter clears on ACCESS entry and increments each ACCESS cycle without p_ack.
  - When it reaches TIMEOUT_CYCLES, p_req drops and the FSM goes to ERR1.
  - p_ack in the same cycle as the timeout takes precedence over the timeout.
- Without the macro: no counter is built and ACCESS waits for p_ack indefinitely.

Test Plan:
- Word read at 0xC0000104, p_ack in 1st ACCESS cycle with p_rdata=0x12345678 -> p_addr=0x04, p_be=4'hF, p_we=0; hready_out low 1 cycle, then high with hrdata=0x12345678 and hresp OKAY.
- Byte write at 0xC0000103, hwdata=0xAB000000, p_ack after 3 wait cycles -> p_be=4'b1000, p_wdata=0xAB000000, p_we=1; hready_out low 4 cycles, then one OKAY cycle.
- Halfword read at addr[0]=1 -> p_req stays 0; ERR1 (hready 0, ERROR), then ERR2 (hready 1, ERROR).
- p_ack with p_err=1 -> two-cycle ERROR response; a back-to-back accepted write in ERR2 enters ACCESS the next cycle.
- rst_i asserted during ACCESS -> next edge p_req=0, hready_out=1, hresp OKAY; a p_ack one cycle later causes no response.
- AIRI5C_PERIPH_BRIDGE_TIMEOUT_EN set, TIMEOUT_CYCLES=4, p_ack never asserted -> p_req falls after 4 ACCESS cycles, then ERROR response; without the macro, hready_out stays 0 for 100 cycles.

Source files
------------

// File: rtl/airi5c_periph_bridge.sv
// airi5c_periph_bridge
// HASTI (AHB-lite) slave bridge for one internal peripheral. Converts the
// pipelined address/data phases into a registered req/ack handshake and
// produces a two-cycle ERROR response for illegal accesses and for
// peripheral-reported errors. Every output is driven from a register.
//
// Optional feature: define AIRI5C_PERIPH_BRIDGE_TIMEOUT_EN to build an access
// watchdog that forces an ERROR response after TIMEOUT_CYCLES ACCESS cycles
// without p_ack. Without it, ACCESS waits for p_ack indefinitely.

`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif
`ifndef HASTI_RESP_OKAY
`define HASTI_RESP_OKAY 1'b0
`endif
`ifndef HASTI_RESP_ERROR
`define HASTI_RESP_ERROR 1'b1
`endif

module airi5c_periph_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         hsel,
  input  logic [31:0]                  haddr,
  input  logic                         hwrite,
  input  logic [2:0]                   hsize,
  input  logic [1:0]                   htrans,
  input  logic [31:0]                  hwdata,
  input  logic                         hready_in,
  output logic                         hready_out,
  output logic [`HASTI_RESP_WIDTH-1:0] hresp,
  output logic [31:0]                  hrdata,
  output logic                         p_req,
  output logic                         p_we,
  output logic [ADDR_WIDTH-1:0]        p_addr,
  output logic [3:0]                   p_be,
  output logic [31:0]                  p_wdata,
  input  logic                         p_ack,
  input  logic                         p_err,
  input  logic [31:0]                  p_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RESP   = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_t;

  // Size/alignment legality: byte always, halfword on even, word on 4-aligned.
  function automatic logic f_legal(input logic [2:0] size, input logic [1:0] lsb);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~lsb[0];
      3'd2:    ok = (lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by a legal transfer of the given size and offset.
  function automatic logic [3:0] f_byte_en(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] be;
    case (size)
      3'd0:    be = 4'b0001 << lsb;
      3'd1:    be = 4'b0011 << {lsb[1], 1'b0};
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  state_t r_state;
  state_t w_next;

  logic                         r_hready;
  logic [`HASTI_RESP_WIDTH-1:0] r_hresp;
  logic [31:0]                  r_hrdata;
  logic                         r_p_req;
  logic                         r_p_we;
  logic [ADDR_WIDTH-1:0]        r_p_addr;
  logic [3:0]                   r_p_be;
  logic [31:0]                  r_p_wdata;

  logic w_accept;
  logic w_can_accept;
  logic w_legal;
  logic w_start;
  logic w_done_ok;
  logic w_done_err;
  logic w_timeout;
  logic w_unused;

  assign w_accept   = hsel & htrans[1] & hready_in;
  assign w_legal    = f_legal(hsize, haddr[1:0]);
  assign w_done_ok  = (r_state == S_ACCESS) & p_ack & ~p_err;
  assign w_done_err = (r_state == S_ACCESS) & p_ack & p_err;
  assign w_start    = w_can_accept & w_accept & w_legal;
  assign w_unused   = &{1'b0, haddr[31:ADDR_WIDTH], htrans[0]};

`ifdef AIRI5C_PERIPH_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;

  // Access watchdog: zero outside ACCESS, counts ACCESS cycles without ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else if (r_state != S_ACCESS) begin
      r_to_cnt <= '0;
    end else if (!p_ack) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  // The last waiting cycle without ack expires the access; an ack wins.
  assign w_timeout = (r_state == S_ACCESS) & ~p_ack &
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state logic; new transfers are only taken while hready_out is high.
  always_comb begin
    w_next       = r_state;
    w_can_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_can_accept = 1'b1;
        w_next       = S_IDLE;
      end
      S_ACCESS: begin
        if (w_done_ok) begin
          w_next = S_RESP;
        end else if (w_done_err || w_timeout) begin
          w_next = S_ERR1;
        end else begin
          w_next = S_ACCESS;
        end
      end
      S_RESP, S_ERR2: begin
        w_can_accept = 1'b1;
        w_next       = S_IDLE;
      end
      S_ERR1: begin
        w_next = S_ERR2;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_can_accept && w_accept) begin
      w_next = w_legal ? S_ACCESS : S_ERR1;
    end else begin
      w_next = w_next;
    end
  end

  // State register plus all registered bus and peripheral outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_hready  <= 1'b1;
      r_hresp   <= `HASTI_RESP_OKAY;
      r_hrdata  <= 32'h0000_0000;
      r_p_req   <= 1'b0;
      r_p_we    <= 1'b0;
      r_p_addr  <= '0;
      r_p_be    <= 4'b0000;
      r_p_wdata <= 32'h0000_0000;
    end else begin
      r_state  <= w_next;
      r_hready <= (w_next == S_IDLE) | (w_next == S_RESP) | (w_next == S_ERR2);
      r_hresp  <= ((w_next == S_ERR1) | (w_next == S_ERR2)) ? `HASTI_RESP_ERROR
                                                           : `HASTI_RESP_OKAY;
      if (w_start) begin
        r_p_req  <= 1'b1;
        r_p_we   <= hwrite;
        r_p_addr <= haddr[ADDR_WIDTH-1:0];
        r_p_be   <= f_byte_en(hsize, haddr[1:0]);
      end else if ((r_state == S_ACCESS) && (w_next != S_ACCESS)) begin
        r_p_req <= 1'b0;
      end else begin
        r_p_req <= r_p_req;
      end
      // hwdata is held for the whole data phase, so refresh on every ACCESS edge.
      if (r_state == S_ACCESS) begin
        r_p_wdata <= hwdata;
      end else begin
        r_p_wdata <= r_p_wdata;
      end
      if (w_done_ok) begin
        r_hrdata <= r_p_we ? 32'h0000_0000 : p_rdata;
      end else begin
        r_hrdata <= r_hrdata;
      end
    end
  end

  assign hready_out = r_hready;
  assign hresp      = r_hresp;
  assign hrdata     = r_hrdata;
  assign p_req      = r_p_req;
  assign p_we       = r_p_we;
  assign p_addr     = r_p_addr;
  assign p_be       = r_p_be;
  assign p_wdata    = r_p_wdata;

endmodule

// File: tb/tb_airi5c_periph_bridge.sv
// Self-checking bench for airi5c_periph_bridge: directed scenarios plus
// randomized transfers checked against a behavioural AHB slave model.
// Inputs are driven and outputs sampled on the falling clock edge.

`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif
`ifndef HASTI_RESP_OKAY
`define HASTI_RESP_OKAY 1'b0
`endif
`ifndef HASTI_RESP_ERROR
`define HASTI_RESP_ERROR 1'b1
`endif

module tb_airi5c_periph_bridge;

  localparam int TB_TIMEOUT = 4;

  logic                         clk_i = 1'b0;
  logic                         rst_i;
  logic                         hsel;
  logic [31:0]                  haddr;
  logic                         hwrite;
  logic [2:0]                   hsize;
  logic [1:0]                   htrans;
  logic [31:0]                  hwdata;
  logic                         hready_in;
  logic                         hready_out;
  logic [`HASTI_RESP_WIDTH-1:0] hresp;
  logic [31:0]                  hrdata;
  logic                         p_req;
  logic                         p_we;
  logic [7:0]                   p_addr;
  logic [3:0]                   p_be;
  logic [31:0]                  p_wdata;
  logic                         p_ack;
  logic                         p_err;
  logic [31:0]                  p_rdata;

  logic        tb_block;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hrdata;

  // Single slave on the bus: the bus hready follows this slave unless a
  // foreign stall is injected.
  assign hready_in = hready_out & ~tb_block;

  always #5 clk_i = ~clk_i;

  airi5c_periph_bridge #(
    .ADDR_WIDTH    (8),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .hsel      (hsel),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .htrans    (htrans),
    .hwdata    (hwdata),
    .hready_in (hready_in),
    .hready_out(hready_out),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .p_req     (p_req),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_be      (p_be),
    .p_wdata   (p_wdata),
    .p_ack     (p_ack),
    .p_err     (p_err),
    .p_rdata   (p_rdata)
  );

  // Model: a transfer of 2**size bytes is legal when naturally aligned.
  function automatic bit m_legal(input logic [31:0] a, input logic [2:0] sz);
    int n;
    if (sz > 3'd2) return 1'b0;
    n = 1 << sz;
    return (int'(a[1:0]) % n) == 0;
  endfunction

  // Model: lanes covered by the naturally aligned container of the access.
  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] sz);
    int n;
    int start;
    logic [3:0] be;
    n = 1 << sz;
    start = (int'(a[1:0]) / n) * n;
    be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i >= start && i < start + n) be[i] = 1'b1;
    end
    return be;
  endfunction

  // One complete transfer. Entered and left on a falling edge in a cycle where
  // hready_out is high, so calls can be chained back-to-back.
  task automatic xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                      input logic [31:0] wd, input int waits, input logic perr,
                      input logic [31:0] rd);
    bit         legal;
    logic [3:0] be;
    int         bad;
    legal = m_legal(a, sz);
    be    = legal ? m_be(a, sz) : 4'b0000;
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
    @(negedge clk_i);
    hsel = 1'b0; htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom);
    hsize = 3'($urandom); hwdata = wd;
    if (legal) begin
      checks++;
      if ({p_req, p_we, p_addr, p_be, hready_out} !== {1'b1, wr, a[7:0], be, 1'b0}) begin
        errors++;
        $display("FAIL access_entry: req/we/addr/be/hready got %b/%b/%h/%b/%b expected 1/%b/%h/%b/0",
                 p_req, p_we, p_addr, p_be, hready_out, wr, a[7:0], be);
      end
      bad = 0;
      for (int i = 0; i <= waits; i++) begin
        if (hready_out !== 1'b0 || p_req !== 1'b1) bad++;
        p_ack   = (i == waits);
        p_err   = (i == waits) ? perr : 1'($urandom);
        p_rdata = (i == waits) ? rd : $urandom;
        @(negedge clk_i);
      end
      p_ack = 1'b0; p_err = 1'($urandom); p_rdata = $urandom;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL access_wait: %0d of %0d wait cycles had hready high or p_req low, expected 0",
                 bad, waits + 1);
      end
      if (!perr) begin
        exp_hrdata = wr ? 32'h0 : rd;
        checks++;
        if ({hready_out, hresp, p_req, hrdata} !== {1'b1, `HASTI_RESP_OKAY, 1'b0, exp_hrdata}) begin
          errors++;
          $display("FAIL resp_okay: hready/hresp/req/hrdata got %b/%b/%b/%h expected 1/0/0/%h",
                   hready_out, hresp, p_req, hrdata, exp_hrdata);
        end
        if (wr) begin
          checks++;
          if (p_wdata !== wd) begin
            errors++;
            $display("FAIL p_wdata: got %h expected %h", p_wdata, wd);
          end
        end
      end
    end
    if (!legal || perr) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({hready_out, hresp, p_req, hrdata} !== {(k == 1), `HASTI_RESP_ERROR, 1'b0, exp_hrdata}) begin
          errors++;
          $display("FAIL err_cycle%0d: hready/hresp/req/hrdata got %b/%b/%b/%h expected %0d/1/0/%h",
                   k + 1, hready_out, hresp, p_req, hrdata, k, exp_hrdata);
        end
        if (k == 0) @(negedge clk_i);
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    exp_hrdata = 32'h0;
    checks++;
    if ({hready_out, hresp, hrdata, p_req, p_we, p_addr, p_be, p_wdata} !==
        {1'b1, `HASTI_RESP_OKAY, 32'h0, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_values: hready/hresp/hrdata/req/we/addr/be/wdata got %b/%b/%h/%b/%b/%h/%h/%h expected 1/0/0/0/0/0/0/0",
               hready_out, hresp, hrdata, p_req, p_we, p_addr, p_be, p_wdata);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_not_accepted;
    for (int i = 0; i < 4; i++) begin
      haddr = 32'hC000_0010; hsize = 3'd2; hwrite = 1'b0;
      case (i)
        0: begin hsel = 1'b1; htrans = 2'b01; end
        1: begin hsel = 1'b0; htrans = 2'b10; end
        2: begin hsel = 1'b1; htrans = 2'b10; tb_block = 1'b1; end
        default: begin hsel = 1'b0; htrans = 2'b00; p_ack = 1'b1; p_rdata = $urandom; end
      endcase
      @(negedge clk_i);
      hsel = 1'b0; htrans = 2'b00; tb_block = 1'b0; p_ack = 1'b0;
      checks++;
      if ({hready_out, hresp, p_req, hrdata} !== {1'b1, `HASTI_RESP_OKAY, 1'b0, exp_hrdata}) begin
        errors++;
        $display("FAIL not_accepted%0d: hready/hresp/req/hrdata got %b/%b/%b/%h expected 1/0/0/%h",
                 i, hready_out, hresp, p_req, hrdata, exp_hrdata);
      end
    end
  endtask

  task automatic test_directed;
    xfer(32'hC000_0104, 3'd2, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678);
    @(negedge clk_i);
    xfer(32'hC000_0103, 3'd0, 1'b1, 32'hAB00_0000, 3, 1'b0, 32'h5555_5555);
    @(negedge clk_i);
    xfer(32'hC000_0101, 3'd1, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    @(negedge clk_i);
    xfer(32'hC000_0102, 3'd1, 1'b0, 32'h0, 1, 1'b0, 32'h0000_BEEF);
    xfer(32'hC000_0020, 3'd3, 1'b1, 32'h0, 0, 1'b0, 32'h0);
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back;
    xfer(32'hC000_0040, 3'd2, 1'b0, 32'h0, 1, 1'b1, 32'hFFFF_FFFF);
    xfer(32'hC000_0044, 3'd2, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 32'h0);
    xfer(32'hC000_0048, 3'd2, 1'b0, 32'h0, 2, 1'b0, 32'h8765_4321);
    xfer(32'hC000_0049, 3'd0, 1'b1, 32'h0000_7700, 0, 1'b0, 32'h0);
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_access;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'hC000_0008; hwrite = 1'b0; hsize = 3'd2;
    @(negedge clk_i);
    hsel = 1'b0; htrans = 2'b00;
    checks++;
    if (p_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: p_req got %b expected 1", p_req);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    exp_hrdata = 32'h0;
    checks++;
    if ({p_req, hready_out, hresp} !== {1'b0, 1'b1, `HASTI_RESP_OKAY}) begin
      errors++;
      $display("FAIL rst_mid: req/hready/hresp got %b/%b/%b expected 0/1/0", p_req, hready_out, hresp);
    end
    rst_i = 1'b0; p_ack = 1'b1; p_err = 1'b0; p_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      p_ack = 1'b0;
      checks++;
      if ({hready_out, hresp, p_req, hrdata} !== {1'b1, `HASTI_RESP_OKAY, 1'b0, exp_hrdata}) begin
        errors++;
        $display("FAIL late_ack%0d: hready/hresp/req/hrdata got %b/%b/%b/%h expected 1/0/0/%h",
                 k, hready_out, hresp, p_req, hrdata, exp_hrdata);
      end
    end
  endtask

  task automatic test_timeout;
    int bad;
    int n_wait;
`ifdef AIRI5C_PERIPH_BRIDGE_TIMEOUT_EN
    n_wait = TB_TIMEOUT;
`else
    n_wait = 100;
`endif
    hsel = 1'b1; htrans = 2'b10; haddr = 32'hC000_0030; hwrite = 1'b0; hsize = 3'd2;
    @(negedge clk_i);
    hsel = 1'b0; htrans = 2'b00;
    bad = 0;
    for (int i = 0; i < n_wait; i++) begin
      if (hready_out !== 1'b0 || p_req !== 1'b1) bad++;
      @(negedge clk_i);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_wait: %0d of %0d cycles left ACCESS early, expected 0", bad, n_wait);
    end
`ifdef AIRI5C_PERIPH_BRIDGE_TIMEOUT_EN
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({hready_out, hresp, p_req} !== {(k == 1), `HASTI_RESP_ERROR, 1'b0}) begin
        errors++;
        $display("FAIL timeout_err%0d: hready/hresp/req got %b/%b/%b expected %0d/1/0",
                 k + 1, hready_out, hresp, p_req, k);
      end
      @(negedge clk_i);
    end
`else
    checks++;
    if ({hready_out, p_req} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL no_timeout: hready/req got %b/%b expected 0/1", hready_out, p_req);
    end
    p_ack = 1'b1; p_err = 1'b0; p_rdata = 32'h0BAD_F00D;
    @(negedge clk_i);
    p_ack = 1'b0;
    exp_hrdata = 32'h0BAD_F00D;
    checks++;
    if ({hready_out, hresp, hrdata} !== {1'b1, `HASTI_RESP_OKAY, exp_hrdata}) begin
      errors++;
      $display("FAIL no_timeout_resp: hready/hresp/hrdata got %b/%b/%h expected 1/0/%h",
               hready_out, hresp, hrdata, exp_hrdata);
    end
    @(negedge clk_i);
`endif
  endtask

  task automatic test_random;
    logic [2:0] sz;
    for (int n = 0; n < 60; n++) begin
      sz = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      xfer({$urandom} | 32'hC000_0000 & 32'hFFFF_FFFF, sz, 1'($urandom), $urandom,
           $urandom_range(0, 4), ($urandom_range(0, 7) == 0), $urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk_i);
    end
  endtask

  initial begin
    rst_i = 1'b1; hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
    htrans = 2'b00; hwdata = 32'h0; p_ack = 1'b0; p_err = 1'b0; p_rdata = 32'h0;
    tb_block = 1'b0; exp_hrdata = 32'h0;
    test_reset();
    test_not_accepted();
    test_directed();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
